// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared operation codes, FSM states and PC constants for alu_mc.
package alu_mc_pkg;

    // Codes 0-6 match the legacy 3-bit ALU select bit-for-bit.
    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_XOR  = 4'd4,
        OP_BEQ  = 4'd5,
        OP_J    = 4'd6,
        OP_SLT  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MULU = 4'd11,
        OP_DIVU = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv: iterative unsigned shift-add multiplier / restoring divider.
// One step per cycle for WIDTH cycles after i_start. o_lo/o_hi present the
// value the step taken on the coming edge will produce, so the parent can
// capture the final result on the same edge as the last step.
module alu_mc_muldiv
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] r_lo;   // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0] r_m;    // multiplicand / divisor
    logic             r_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Next-step datapath for both multiply and divide.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_rem_sh = {r_hi, r_lo[WIDTH-1]};
        w_diff   = {1'b0, w_rem_sh} - {2'b00, r_m};
        w_neg    = w_diff[WIDTH+1];
        if (r_div) begin
            w_hi_nxt = w_neg ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], ~w_neg};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Operand latch on start, then one iteration per cycle until cnt hits 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_div <= 1'b0;
        end else if (i_start) begin
            r_cnt <= CW'(WIDTH);
            r_hi  <= '0;
            r_lo  <= i_a;
            r_m   <= i_b;
            r_div <= i_is_div;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    assign o_done = (r_cnt == CW'(1));
    assign o_lo   = w_lo_nxt;
    assign o_hi   = w_hi_nxt;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready handshake.
// Single-cycle ops complete in one cycle; MULU and DIVU (b != 0) iterate
// WIDTH cycles in alu_mc_muldiv. Results are held in DONE until taken.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_imm,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_y_hi,
    output logic             o_zero,
    output logic             o_dbz,
    output logic             o_illegal
);

    localparam int unsigned SW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_nxt;

    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_y_hi;
    logic             r_zero;
    logic             r_dbz;
    logic             r_ill;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_start_md;
    logic             w_md_last;
    logic             w_md_fin;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;

    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_br_off;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_j_tgt;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_sra;
    logic             w_lt;
    logic             w_unused_imm;

    logic [WIDTH-1:0] w_sc_y;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_dbz;
    logic             w_sc_ill;

    assign w_accept   = i_in_valid & o_in_ready;
    assign w_is_mul   = (i_op == OP_MULU);
    assign w_is_div   = (i_op == OP_DIVU);
    assign w_b_zero   = (i_b == '0);
    // Divide by zero bypasses the iterative path and finishes in one cycle.
    assign w_start_md = w_accept & (w_is_mul | (w_is_div & ~w_b_zero));
    assign w_md_fin   = ((r_state == ST_MUL) || (r_state == ST_DIV)) && w_md_last;

    assign w_pc4        = i_pc + WIDTH'(PC_STEP);
    assign w_br_off     = WIDTH'(signed'(i_imm[15:0])) << 2;
    assign w_br_tgt     = w_pc4 + w_br_off;
    assign w_j_tgt      = {w_pc4[WIDTH-1:WIDTH-4], i_imm[WIDTH-7:0], 2'b00};
    assign w_shamt      = i_b[SW-1:0];
    assign w_sra        = $unsigned($signed(i_a) >>> w_shamt);
    assign w_lt         = ($signed(i_a) < $signed(i_b));
    assign w_unused_imm = &{1'b0, i_imm};

    alu_mc_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_start_md),
        .i_is_div (w_is_div),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_done   (w_md_last),
        .o_lo     (w_md_lo),
        .o_hi     (w_md_hi)
    );

    // Single-cycle result selection, including divide-by-zero and illegal ops.
    always_comb begin
        w_sc_y   = '0;
        w_sc_hi  = '0;
        w_sc_dbz = 1'b0;
        w_sc_ill = 1'b0;
        case (i_op)
            OP_AND:  w_sc_y = i_a & i_b;
            OP_OR:   w_sc_y = i_a | i_b;
            OP_ADD:  w_sc_y = i_a + i_b;
            OP_SUB:  w_sc_y = i_a + ~i_b + WIDTH'(1);
            OP_XOR:  w_sc_y = i_a ^ i_b;
            OP_BEQ:  w_sc_y = (i_a == i_b) ? w_br_tgt : w_pc4;
            OP_J:    w_sc_y = w_j_tgt;
            OP_SLT:  w_sc_y = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLL:  w_sc_y = i_a << w_shamt;
            OP_SRL:  w_sc_y = i_a >> w_shamt;
            OP_SRA:  w_sc_y = w_sra;
            OP_MULU: w_sc_y = '0;
            OP_DIVU: begin
                if (w_b_zero) begin
                    w_sc_y   = '1;
                    w_sc_hi  = i_a;
                    w_sc_dbz = 1'b1;
                end
            end
            default: w_sc_ill = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE may accept a new op on the edge its result is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = ST_MUL;
                    end else if (w_is_div && !w_b_zero) begin
                        w_state_nxt = ST_DIV;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else if ((r_state == ST_DONE) && i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_md_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: o_in_ready = 1'b1;
            ST_DONE: begin
                o_out_valid = 1'b1;
                o_in_ready  = i_out_ready;
            end
            default: begin
                o_in_ready  = 1'b0;
                o_out_valid = 1'b0;
            end
        endcase
    end

    // Result registers: loaded on single-cycle accept or on the last iteration.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_y    <= '0;
            r_y_hi <= '0;
            r_zero <= 1'b0;
            r_dbz  <= 1'b0;
            r_ill  <= 1'b0;
        end else if (w_accept && !w_start_md) begin
            r_y    <= w_sc_y;
            r_y_hi <= w_sc_hi;
            r_zero <= (w_sc_y == '0);
            r_dbz  <= w_sc_dbz;
            r_ill  <= w_sc_ill;
        end else if (w_md_fin) begin
            r_y    <= w_md_lo;
            r_y_hi <= w_md_hi;
            r_zero <= (w_md_lo == '0);
            r_dbz  <= 1'b0;
            r_ill  <= 1'b0;
        end
    end

    assign o_y       = r_y;
    assign o_y_hi    = r_y_hi;
    assign o_zero    = r_zero;
    assign o_dbz     = r_dbz;
    assign o_illegal = r_ill;

endmodule
